// File: rtl/axis_sample_framer_if.sv
// AXI4-Stream master bus carrying framed samples.
//   m00_axis_tvalid : data valid (master -> slave)
//   m00_axis_tready : downstream ready (slave -> master)
//   m00_axis_tlast  : last sample of a frame
//   m00_axis_tdata  : sign-extended sample
//   m00_axis_tstrb  : byte strobes
interface axis_sample_framer_if #(
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32
);

  logic                                  m00_axis_tvalid;
  logic                                  m00_axis_tready;
  logic                                  m00_axis_tlast;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata;
  logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb;

  modport master (
    output m00_axis_tvalid,
    output m00_axis_tlast,
    output m00_axis_tdata,
    output m00_axis_tstrb,
    input  m00_axis_tready
  );

  modport slave (
    input  m00_axis_tvalid,
    input  m00_axis_tlast,
    input  m00_axis_tdata,
    input  m00_axis_tstrb,
    output m00_axis_tready
  );

endinterface

// File: rtl/axis_sample_framer.sv
// Packs a strobed stream of signed samples into AXI4-Stream frames.
// Each accepted sample is sign-extended and queued in a small FIFO together with
// a last flag; the FIFO head drives the output stream directly.
//
// Ports:
//   m00_axis_aclk    : clock, rising edge
//   m00_axis_aresetn : asynchronous active-low reset
//   sample_valid     : one-cycle strobe for sample_data (no backpressure)
//   sample_data      : signed input sample
//   frame_flush      : close the current frame early
//   overflow_clr     : clear the sticky overflow flag
//   m00_axis         : AXI4-Stream master (tvalid/tready/tlast/tdata/tstrb)
//   overflow         : sticky, set when a sample is dropped on a full FIFO
//   fifo_count       : occupied FIFO entries
module axis_sample_framer #(
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned SAMPLE_WIDTH           = 16,
  parameter int unsigned FRAME_LEN              = 64,
  parameter int unsigned FIFO_DEPTH             = 16
) (
  input  logic                          m00_axis_aclk,
  input  logic                          m00_axis_aresetn,
  input  logic                          sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]       sample_data,
  input  logic                          frame_flush,
  input  logic                          overflow_clr,
  axis_sample_framer_if.master          m00_axis,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DataW = C_M00_AXIS_TDATA_WIDTH;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdxW  = $clog2(FRAME_LEN);

  // FIFO entry: {last, data}
  logic [DataW:0]    mem [FIFO_DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [IdxW-1:0]   frame_idx_q, frame_idx_d;
  logic              flush_pend_q, flush_pend_d;
  logic              overflow_q, overflow_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              last_flag;
  logic [DataW-1:0]  sample_ext;
  logic [DataW:0]    head_entry;

  // Handshake decode
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    pop        = !fifo_empty && m00_axis.m00_axis_tready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push       = sample_valid && (!fifo_full || pop);
    drop       = sample_valid && fifo_full && !pop;
    last_flag  = (frame_idx_q == IdxW'(FRAME_LEN - 1)) || frame_flush || flush_pend_q;
  end

  // Sign extension, written so it also works when the sample fills the bus.
  always_comb begin
    sample_ext                   = {DataW{sample_data[SAMPLE_WIDTH-1]}};
    sample_ext[SAMPLE_WIDTH-1:0] = sample_data;
  end

  // Next-state logic
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    frame_idx_d  = frame_idx_q;
    flush_pend_d = flush_pend_q;
    overflow_d   = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (push) begin
      if (last_flag) begin
        frame_idx_d  = '0;
        flush_pend_d = 1'b0;
      end else begin
        frame_idx_d  = frame_idx_q + IdxW'(1);
      end
    end else if (frame_flush) begin
      // Remember the flush until a sample can carry tlast; repeats collapse.
      flush_pend_d = 1'b1;
    end

    // Drop beats clear when both happen together.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_idx_q  <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_idx_q  <= frame_idx_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage has no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge m00_axis_aclk) begin
    if (push) begin
      mem[wr_ptr_q] <= {last_flag, sample_ext};
    end
  end

  // Outputs; head data is masked while empty so reset drives tdata/tlast to zero.
  always_comb begin
    head_entry               = mem[rd_ptr_q];
    m00_axis.m00_axis_tvalid = !fifo_empty;
    m00_axis.m00_axis_tdata  = fifo_empty ? '0 : head_entry[DataW-1:0];
    m00_axis.m00_axis_tlast  = !fifo_empty && head_entry[DataW];
    m00_axis.m00_axis_tstrb  = '1;
    overflow                 = overflow_q;
    fifo_count               = count_q;
  end

endmodule
